// File: rtl/ndma_pkg.sv
// Shared types and constants for the DMA channel scheduler: FSM state encoding,
// engine config register map and sizing helpers.
package ndma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SRC,
        WR_DST,
        WR_LEN,
        WR_GO,
        WAIT_DONE,
        RESP
    } sched_state_t;

    localparam logic [31:0] NDMA_SRC_OFF  = 32'h0000_0000;
    localparam logic [31:0] NDMA_DST_OFF  = 32'h0000_0004;
    localparam logic [31:0] NDMA_LEN_OFF  = 32'h0000_0008;
    localparam logic [31:0] NDMA_CTRL_OFF = 32'h0000_000C;
    localparam logic [31:0] NDMA_GO       = 32'h0000_0001;

    function automatic int tx_cnt_bits(input int max_tx);
        return (max_tx > 1) ? $clog2(max_tx) : 1;
    endfunction

endpackage

// File: rtl/ndma_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after last+1 (mod NumCh).
module ndma_rr_arb #(
    parameter int NumCh = 4,
    localparam int IdxW = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic [NumCh-1:0] req,
    input  logic [IdxW-1:0]  last_ptr,
    output logic [NumCh-1:0] gnt,
    output logic [IdxW-1:0]  idx
);

    logic [IdxW-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        for (int k = NumCh; k >= 1; k--) begin
            cand = IdxW'((int'(last_ptr) + k) % NumCh);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ndma_chan_sched.sv
// Multi-channel front-end for the single-transfer DMA engine: round-robin pick,
// four config writes, wait for done (or timeout), then a per-channel response pulse.
module ndma_chan_sched
    import ndma_pkg::*;
#(
    parameter int          NumCh         = 4,
    parameter int          MaxTxSize     = 256,
    parameter logic [31:0] CfgBase       = 32'h0000_0000,
    parameter int          TimeoutCycles = 4096,
    localparam int         TxCntBits     = tx_cnt_bits(MaxTxSize),
    localparam int         IdxW          = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumCh-1:0]                ch_req_i,
    input  logic [NumCh-1:0][31:0]          ch_src_i,
    input  logic [NumCh-1:0][31:0]          ch_dst_i,
    input  logic [NumCh-1:0][TxCntBits-1:0] ch_len_i,
    output logic [NumCh-1:0]                ch_gnt_o,
    output logic [NumCh-1:0]                ch_done_o,
    output logic [NumCh-1:0]                ch_err_o,
    output logic                            busy_o,
    output logic                            cfg_req_o,
    output logic                            cfg_we_o,
    output logic [31:0]                     cfg_addr_o,
    output logic [31:0]                     cfg_wdata_o,
    input  logic                            cfg_gnt_i,
    input  logic                            cfg_rvalid_i,
    input  logic                            dma_done_i
);

    localparam int ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [ToW-1:0] ToLast = (TimeoutCycles == 0) ? '0 : ToW'(TimeoutCycles - 1);

    sched_state_t            state_q;
    logic [IdxW-1:0]         ptr_q, idx_q, arb_idx;
    logic [NumCh-1:0]        arb_gnt, done_q, err_q;
    logic [31:0]             dst_q;
    logic [TxCntBits-1:0]    len_q;
    logic                    cfg_req_q;
    logic [31:0]             cfg_addr_q, cfg_wdata_q;
    logic [ToW-1:0]          to_cnt_q;
    logic                    dma_done_q;
    logic                    idle, done_rise, to_hit;
    logic                    unused_rvalid;

    ndma_rr_arb #(.NumCh(NumCh)) u_arb (
        .req      (ch_req_i),
        .last_ptr (ptr_q),
        .gnt      (arb_gnt),
        .idx      (arb_idx)
    );

    assign idle      = (state_q == IDLE);
    assign done_rise = dma_done_i & ~dma_done_q;
    assign to_hit    = (TimeoutCycles != 0) && (to_cnt_q == ToLast);

    // Grant is combinational from the arbiter; held low while reset is asserted.
    assign ch_gnt_o      = (idle && rst_ni) ? arb_gnt : '0;
    assign ch_done_o     = done_q;
    assign ch_err_o      = err_q;
    assign busy_o        = ~idle;
    assign cfg_req_o     = cfg_req_q;
    assign cfg_we_o      = cfg_req_q;
    assign cfg_addr_o    = cfg_addr_q;
    assign cfg_wdata_o   = cfg_wdata_q;
    assign unused_rvalid = cfg_rvalid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            cfg_req_q   <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            to_cnt_q    <= '0;
            dma_done_q  <= 1'b0;
        end else begin
            dma_done_q <= dma_done_i;
            done_q     <= '0;
            err_q      <= '0;
            case (state_q)
                IDLE: begin
                    if (|ch_req_i) begin
                        ptr_q <= arb_idx;
                        idx_q <= arb_idx;
                        dst_q <= ch_dst_i[arb_idx];
                        len_q <= ch_len_i[arb_idx];
                        if (ch_len_i[arb_idx] != '0) begin
                            state_q     <= WR_SRC;
                            cfg_req_q   <= 1'b1;
                            cfg_addr_q  <= CfgBase + NDMA_SRC_OFF;
                            cfg_wdata_q <= ch_src_i[arb_idx];
                        end else begin
                            // Zero-length descriptor completes without touching the engine.
                            state_q <= RESP;
                            done_q  <= NumCh'(1) << arb_idx;
                        end
                    end
                end
                WR_SRC: if (cfg_gnt_i) begin
                    state_q     <= WR_DST;
                    cfg_addr_q  <= CfgBase + NDMA_DST_OFF;
                    cfg_wdata_q <= dst_q;
                end
                WR_DST: if (cfg_gnt_i) begin
                    state_q     <= WR_LEN;
                    cfg_addr_q  <= CfgBase + NDMA_LEN_OFF;
                    cfg_wdata_q <= 32'(len_q);
                end
                WR_LEN: if (cfg_gnt_i) begin
                    state_q     <= WR_GO;
                    cfg_addr_q  <= CfgBase + NDMA_CTRL_OFF;
                    cfg_wdata_q <= NDMA_GO;
                end
                WR_GO: if (cfg_gnt_i) begin
                    state_q     <= WAIT_DONE;
                    cfg_req_q   <= 1'b0;
                    cfg_addr_q  <= '0;
                    cfg_wdata_q <= '0;
                    to_cnt_q    <= '0;
                end
                WAIT_DONE: begin
                    // A stale high level on dma_done_i is not a completion; only an edge counts.
                    if (done_rise) begin
                        state_q <= RESP;
                        done_q  <= NumCh'(1) << idx_q;
                    end else if (to_hit) begin
                        state_q <= RESP;
                        err_q   <= NumCh'(1) << idx_q;
                    end else if (to_cnt_q != {ToW{1'b1}}) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ndma_chan_sched.sv
// Directed self-checking bench for ndma_chan_sched (4 channels, 32-cycle timeout).
module tb_ndma_chan_sched;

    localparam int NCH = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NCH-1:0]       ch_req_i;
    logic [NCH-1:0][31:0] ch_src_i, ch_dst_i;
    logic [NCH-1:0][7:0]  ch_len_i;
    logic [NCH-1:0]       ch_gnt_o, ch_done_o, ch_err_o;
    logic                 busy_o, cfg_req_o, cfg_we_o;
    logic [31:0]          cfg_addr_o, cfg_wdata_o;
    logic                 cfg_gnt_i, cfg_rvalid_i, dma_done_i;

    int checks = 0;
    int errors = 0;
    int nwr    = 0;
    int n0;
    logic [NCH-1:0] rr_exp [5];

    ndma_chan_sched #(
        .NumCh(NCH), .MaxTxSize(256), .CfgBase(32'h0), .TimeoutCycles(32)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ch_req_i(ch_req_i), .ch_src_i(ch_src_i), .ch_dst_i(ch_dst_i), .ch_len_i(ch_len_i),
        .ch_gnt_o(ch_gnt_o), .ch_done_o(ch_done_o), .ch_err_o(ch_err_o), .busy_o(busy_o),
        .cfg_req_o(cfg_req_o), .cfg_we_o(cfg_we_o), .cfg_addr_o(cfg_addr_o),
        .cfg_wdata_o(cfg_wdata_o), .cfg_gnt_i(cfg_gnt_i), .cfg_rvalid_i(cfg_rvalid_i),
        .dma_done_i(dma_done_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (cfg_req_o && cfg_gnt_i) nwr <= nwr + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_req"}, {31'b0, cfg_req_o}, 1);
        chk({tag, "_we"}, {31'b0, cfg_we_o}, 1);
        chk({tag, "_addr"}, cfg_addr_o, addr);
        chk({tag, "_data"}, cfg_wdata_o, data);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"}, {31'b0, cfg_req_o}, 0);
        chk({tag, "_busy"}, {31'b0, busy_o}, 0);
        chk({tag, "_gnt"}, {28'b0, ch_gnt_o}, 0);
        chk({tag, "_done"}, {28'b0, ch_done_o}, 0);
        chk({tag, "_err"}, {28'b0, ch_err_o}, 0);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        cyc();
    endtask

    initial begin
        rst_ni = 1'b0; ch_req_i = '0; ch_src_i = '0; ch_dst_i = '0; ch_len_i = '0;
        cfg_gnt_i = 1'b0; cfg_rvalid_i = 1'b0; dma_done_i = 1'b0;
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Reset state, with a request pending that must not be granted.
        repeat (2) cyc();
        ch_req_i = 4'b0100; #1;
        chk_quiet("rst");
        ch_req_i = '0;
        rst_ni = 1'b1;
        cyc();

        // Basic transfer on ch1 with back-to-back config grants.
        ch_src_i[1] = 32'h1000; ch_dst_i[1] = 32'h2000; ch_len_i[1] = 8'd8;
        cfg_gnt_i = 1'b1; ch_req_i = 4'b0010; #1;
        chk("t1_gnt", {28'b0, ch_gnt_o}, 4'b0010);
        chk("t1_busy_pre", {31'b0, busy_o}, 0);
        cyc(); ch_req_i = '0; #1;
        chk("t1_gnt_off", {28'b0, ch_gnt_o}, 0);
        chk_wr("t1_src", 32'h0, 32'h1000);
        cyc(); chk_wr("t1_dst", 32'h4, 32'h2000);
        cyc(); chk_wr("t1_len", 32'h8, 32'd8);
        cyc(); chk_wr("t1_go", 32'hC, 32'h1);
        cyc();
        chk("t1_wait_req", {31'b0, cfg_req_o}, 0);
        chk("t1_wait_busy", {31'b0, busy_o}, 1);
        repeat (19) cyc();
        dma_done_i = 1'b1; #1;
        chk("t1_done_pre", {28'b0, ch_done_o}, 0);
        cyc();
        chk("t1_done", {28'b0, ch_done_o}, 4'b0010);
        chk("t1_err", {28'b0, ch_err_o}, 0);
        cyc(); dma_done_i = 1'b0; #1;
        chk("t1_done_off", {28'b0, ch_done_o}, 0);
        chk("t1_busy_post", {31'b0, busy_o}, 0);

        // Round-robin with all channels requesting zero-length descriptors.
        do_reset();
        ch_len_i = '0; ch_req_i = 4'b1111; #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_gnt%0d", i), {28'b0, ch_gnt_o}, {28'b0, rr_exp[i]});
            cyc();
            chk($sformatf("rr_done%0d", i), {28'b0, ch_done_o}, {28'b0, rr_exp[i]});
            chk($sformatf("rr_nognt%0d", i), {28'b0, ch_gnt_o}, 0);
            cyc();
        end
        ch_req_i = '0; #1;
        cyc();

        // Config grant stalled three cycles in WR_DST.
        do_reset();
        ch_src_i[0] = 32'hA0; ch_dst_i[0] = 32'hB0; ch_len_i[0] = 8'd5;
        cfg_gnt_i = 1'b1; ch_req_i = 4'b0001; #1;
        n0 = nwr;
        chk("st_gnt", {28'b0, ch_gnt_o}, 4'b0001);
        cyc(); ch_req_i = '0; #1;
        chk_wr("st_src", 32'h0, 32'hA0);
        cyc(); cfg_gnt_i = 1'b0; #1; chk_wr("st_dst1", 32'h4, 32'hB0);
        cyc(); chk_wr("st_dst2", 32'h4, 32'hB0);
        cyc(); chk_wr("st_dst3", 32'h4, 32'hB0);
        cyc(); cfg_gnt_i = 1'b1; #1; chk_wr("st_dst4", 32'h4, 32'hB0);
        cyc(); chk_wr("st_len", 32'h8, 32'd5);
        cyc(); chk_wr("st_go", 32'hC, 32'h1);
        cyc();
        chk("st_wait_req", {31'b0, cfg_req_o}, 0);
        chk("st_nwr", nwr - n0, 4);
        dma_done_i = 1'b1;
        cyc();
        chk("st_done", {28'b0, ch_done_o}, 4'b0001);
        cyc(); dma_done_i = 1'b0; #1;
        chk("st_busy_post", {31'b0, busy_o}, 0);

        // Zero-length descriptor on ch2: no config traffic, done on next cycle.
        do_reset();
        ch_len_i[2] = 8'd0; ch_req_i = 4'b0100; #1;
        n0 = nwr;
        chk("z_gnt", {28'b0, ch_gnt_o}, 4'b0100);
        chk("z_req0", {31'b0, cfg_req_o}, 0);
        cyc(); ch_req_i = '0; #1;
        chk("z_done", {28'b0, ch_done_o}, 4'b0100);
        chk("z_req1", {31'b0, cfg_req_o}, 0);
        cyc();
        chk("z_done_off", {28'b0, ch_done_o}, 0);
        chk("z_busy", {31'b0, busy_o}, 0);
        chk("z_nwr", nwr - n0, 0);

        // Timeout on ch3: err exactly 33 cycles after the WR_GO grant cycle.
        ch_src_i[3] = 32'h3000; ch_dst_i[3] = 32'h4000; ch_len_i[3] = 8'd4;
        ch_req_i = 4'b1000; #1;
        chk("to_gnt", {28'b0, ch_gnt_o}, 4'b1000);
        cyc(); ch_req_i = '0;
        cyc(); cyc(); cyc(); #1;
        chk_wr("to_go", 32'hC, 32'h1);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            chk($sformatf("to_quiet%0d", k), {28'b0, ch_err_o | ch_done_o}, 0);
        end
        cyc();
        chk("to_err", {28'b0, ch_err_o}, 4'b1000);
        chk("to_nodone", {28'b0, ch_done_o}, 0);
        cyc();
        chk("to_err_off", {28'b0, ch_err_o}, 0);
        chk("to_busy", {31'b0, busy_o}, 0);

        // Stale high dma_done_i at WR_GO must not count as completion.
        ch_src_i[0] = 32'h5; ch_dst_i[0] = 32'h6; ch_len_i[0] = 8'd1;
        dma_done_i = 1'b1; ch_req_i = 4'b0001; #1;
        chk("sl_gnt", {28'b0, ch_gnt_o}, 4'b0001);
        cyc(); ch_req_i = '0;
        cyc(); cyc(); cyc();
        repeat (6) cyc();
        chk("sl_nodone", {28'b0, ch_done_o}, 0);
        chk("sl_busy", {31'b0, busy_o}, 1);
        dma_done_i = 1'b0;
        cyc(); dma_done_i = 1'b1; #1;
        chk("sl_nodone2", {28'b0, ch_done_o}, 0);
        cyc();
        chk("sl_done", {28'b0, ch_done_o}, 4'b0001);
        cyc(); dma_done_i = 1'b0; #1;
        chk("sl_busy_post", {31'b0, busy_o}, 0);

        // Reset during WR_LEN, then round-robin restarts from pointer 0.
        do_reset();
        ch_len_i[3] = 8'd4; ch_len_i[0] = 8'd4;
        ch_req_i = 4'b1000; #1;
        chk("rl_gnt", {28'b0, ch_gnt_o}, 4'b1000);
        cyc(); ch_req_i = '0;
        cyc(); cyc(); #1;
        chk_wr("rl_len", 32'h8, 32'd4);
        rst_ni = 1'b0; #1;
        chk_quiet("rl_rst");
        cyc(); rst_ni = 1'b1; #1;
        chk_quiet("rl_rel");
        ch_req_i = 4'b1001; #1;
        chk("rl_regnt", {28'b0, ch_gnt_o}, 4'b1000);

        // Reset during WAIT_DONE: no response pulse for the aborted channel.
        cyc(); ch_req_i = '0;
        cyc(); cyc(); cyc(); cyc(); cyc(); #1;
        chk("rw_busy", {31'b0, busy_o}, 1);
        chk("rw_req", {31'b0, cfg_req_o}, 0);
        rst_ni = 1'b0; #1;
        chk_quiet("rw_rst");
        cyc(); rst_ni = 1'b1; #1;
        chk_quiet("rw_rel");
        cyc();
        chk_quiet("rw_after");
        ch_req_i = 4'b0011; #1;
        chk("rw_regnt", {28'b0, ch_gnt_o}, 4'b0010);
        cyc(); ch_req_i = '0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
